// File: rtl/addr_boundary_splitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_split_pkg                                                       |
// | Shared types and helpers for the address boundary splitter.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package addr_split_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_4B = 2'd2;
  localparam logic [1:0] SIZE_8B = 2'd3;

  localparam int BOUNDARY_LOG2_DEF = 12;

  function automatic logic [3:0] beat_bytes(input logic [1:0] size);
    beat_bytes = 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_boundary_splitter_chunk_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_chunk_calc                                                      |
// | Sizes the next burst: min(remaining, bytes to boundary, max burst).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module addr_chunk_calc
  import addr_split_pkg::*;
#(
  parameter int LEN_W         = 16,
  parameter int MAX_BEATS     = 16,
  parameter int BOUNDARY_LOG2 = BOUNDARY_LOG2_DEF,
  parameter int BEATS_W       = $clog2(MAX_BEATS) + 1
) (
  input  logic [BOUNDARY_LOG2-1:0] i_offset,
  input  logic [LEN_W-1:0]         i_rem,
  input  logic [1:0]               i_size,
  output logic [LEN_W:0]           o_chunk,
  output logic [BEATS_W-1:0]       o_beats,
  output logic                     o_last
);

  // Compare width wide enough for every operand so nothing overflows.
  localparam int c_cw0 = (LEN_W + 1 > BOUNDARY_LOG2 + 1) ? LEN_W + 1 : BOUNDARY_LOG2 + 1;
  localparam int c_cw  = (c_cw0 > $clog2(MAX_BEATS) + 4) ? c_cw0 : $clog2(MAX_BEATS) + 4;
  localparam logic [BOUNDARY_LOG2:0] c_bnd = {1'b1, {BOUNDARY_LOG2{1'b0}}};

  logic [BOUNDARY_LOG2:0] w_to_bnd;
  logic [c_cw-1:0]        w_rem;
  logic [c_cw-1:0]        w_bnd;
  logic [c_cw-1:0]        w_max;
  logic [c_cw-1:0]        w_min;

  always_comb begin
    w_to_bnd = c_bnd - {1'b0, i_offset};
    w_rem    = c_cw'(i_rem);
    w_bnd    = c_cw'(w_to_bnd);
    w_max    = c_cw'(MAX_BEATS) << i_size;
    w_min    = w_rem;
    if (w_bnd < w_min) w_min = w_bnd;
    if (w_max < w_min) w_min = w_max;
    o_chunk  = (LEN_W + 1)'(w_min);
    o_beats  = BEATS_W'(w_min >> i_size);
    o_last   = (w_min == w_rem);
  end

endmodule
`default_nettype wire

// File: rtl/addr_boundary_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_boundary_splitter                                               |
// | Splits a linear transfer into beat-aligned bursts that never cross   |
// | a 2**BOUNDARY_LOG2 boundary.                                         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module addr_boundary_splitter
  import addr_split_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 16,
  parameter int MAX_BEATS     = 16,
  parameter int BOUNDARY_LOG2 = BOUNDARY_LOG2_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [LEN_W-1:0]           req_len,
  input  logic [1:0]                 req_size,
  output logic                       burst_valid,
  input  logic                       burst_ready,
  output logic [ADDR_W-1:0]          burst_addr,
  output logic [$clog2(MAX_BEATS):0] burst_beats,
  output logic [1:0]                 burst_size,
  output logic                       burst_last,
  output logic                       req_err
);

  localparam int c_beats_w = $clog2(MAX_BEATS) + 1;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [LEN_W-1:0]       r_rem;
  logic [1:0]             r_size;
  logic                   r_err;

  logic [2:0]             w_mask;
  logic                   w_bad;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_fire;
  logic [LEN_W:0]         w_chunk;
  logic [c_beats_w-1:0]   w_beats;
  logic                   w_last;

  addr_chunk_calc #(
    .LEN_W         (LEN_W),
    .MAX_BEATS     (MAX_BEATS),
    .BOUNDARY_LOG2 (BOUNDARY_LOG2),
    .BEATS_W       (c_beats_w)
  ) u_chunk (
    .i_offset (r_addr[BOUNDARY_LOG2-1:0]),
    .i_rem    (r_rem),
    .i_size   (r_size),
    .o_chunk  (w_chunk),
    .o_beats  (w_beats),
    .o_last   (w_last)
  );

  // Misaligned start, empty length or a partial final beat are all rejected.
  always_comb begin
    w_mask = 3'(beat_bytes(req_size) - 4'd1);
    w_bad  = ((req_addr[2:0] & w_mask) != 3'd0) ||
             (req_len == '0) ||
             ((req_len[2:0] & w_mask) != 3'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_bad) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = SPLIT;
          end
        end
      end
      SPLIT: begin
        w_fire = burst_ready;
        if (burst_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_size <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_addr <= req_addr;
        r_rem  <= req_len;
        r_size <= req_size;
      end else if (w_fire) begin
        r_addr <= r_addr + ADDR_W'(w_chunk);
        r_rem  <= r_rem - LEN_W'(w_chunk);
      end
    end
  end

  always_comb begin
    req_ready   = (r_state == IDLE);
    burst_valid = (r_state == SPLIT);
    burst_addr  = burst_valid ? r_addr : '0;
    burst_beats = burst_valid ? w_beats : '0;
    burst_last  = burst_valid & w_last;
    burst_size  = r_size;
    req_err     = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_boundary_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addr_boundary_splitter                                            |
// | Directed and randomized bench against an arithmetic burst model.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_addr_boundary_splitter;

  localparam int MAX_BEATS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [1:0]  req_size = '0;
  logic        burst_valid;
  logic        burst_ready = 1'b0;
  logic [31:0] burst_addr;
  logic [4:0]  burst_beats;
  logic [1:0]  burst_size;
  logic        burst_last;
  logic        req_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    int          beats;
    bit          last;
    logic [1:0]  size;
  } burst_t;

  burst_t exp_q[$];
  burst_t obs_q[$];

  addr_boundary_splitter #(
    .ADDR_W(32), .LEN_W(16), .MAX_BEATS(MAX_BEATS), .BOUNDARY_LOG2(12)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .burst_valid(burst_valid), .burst_ready(burst_ready),
    .burst_addr(burst_addr), .burst_beats(burst_beats),
    .burst_size(burst_size), .burst_last(burst_last),
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
    $fatal(1);
  end

  // Every accepted burst must be beat-aligned, 1..MAX_BEATS, and stay inside one 4K page.
  always @(posedge clk) begin
    if (!reset && burst_valid && burst_ready) begin
      int bytes;
      int beat;
      beat  = 1 << burst_size;
      bytes = int'(burst_beats) * beat;
      checks++;
      if ((burst_addr % beat) != 0 || burst_beats == 0 || burst_beats > MAX_BEATS ||
          (int'(burst_addr[11:0]) + bytes) > 4096) begin
        errors++;
        $display("FAIL invariant: addr=%h beats=%0d size=%0d, required aligned, 1..16 beats, no 4K cross",
                 burst_addr, burst_beats, burst_size);
      end
    end
  end

  function automatic void build_model(input logic [31:0] addr, input int len, input int size);
    longint a;
    int     rem;
    int     beat;
    int     to_bnd;
    int     chunk;
    burst_t b;
    a    = longint'(addr);
    rem  = len;
    beat = 1 << size;
    exp_q.delete();
    while (rem > 0) begin
      to_bnd = 4096 - int'(a % 4096);
      chunk  = rem;
      if (to_bnd < chunk) chunk = to_bnd;
      if (MAX_BEATS * beat < chunk) chunk = MAX_BEATS * beat;
      b.addr  = a[31:0];
      b.beats = chunk / beat;
      b.last  = (chunk == rem);
      b.size  = size[1:0];
      exp_q.push_back(b);
      a   = (a + longint'(chunk)) % (64'd1 << 32);
      rem = rem - chunk;
    end
  endfunction

  // Presents one request for a single cycle; returns at the negedge after the handshake.
  task automatic send_req(input logic [31:0] a, input int len, input int sz);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len[15:0];
    req_size  = sz[1:0];
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Records bursts as they are accepted until the last one, with random backpressure.
  task automatic collect(input int ready_pct, output bit timeout);
    burst_t b;
    bit     done;
    done    = 1'b0;
    timeout = 1'b0;
    obs_q.delete();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      burst_ready = ($urandom_range(99) < ready_pct);
      if (burst_valid && burst_ready) begin
        b.addr  = burst_addr;
        b.beats = int'(burst_beats);
        b.last  = burst_last;
        b.size  = burst_size;
        obs_q.push_back(b);
        if (burst_last) done = 1'b1;
      end
      @(negedge clk);
    end
    burst_ready = 1'b0;
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || burst_valid !== 1'b0 || burst_last !== 1'b0 || req_err !== 1'b0 ||
        burst_addr !== 32'h0 || burst_beats !== 5'd0 || burst_size !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b last=%b err=%b addr=%h beats=%0d size=%0d, required 1 0 0 0 0 0 0",
               req_ready, burst_valid, burst_last, req_err, burst_addr, burst_beats, burst_size);
    end
    reset = 1'b0;
  endtask

  task automatic test_split(input string name, input logic [31:0] a, input int len,
                            input int sz, input int ready_pct);
    bit timeout;
    build_model(a, len, sz);
    send_req(a, len, sz);
    collect(ready_pct, timeout);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL %s_timeout: got no last burst, required %0d bursts", name, exp_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bursts, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].beats != exp_q[i].beats ||
          obs_q[i].last != exp_q[i].last || obs_q[i].size !== exp_q[i].size) begin
        errors++;
        $display("FAIL %s_burst%0d: got addr=%h beats=%0d last=%0d size=%0d, required addr=%h beats=%0d last=%0d size=%0d",
                 name, i, obs_q[i].addr, obs_q[i].beats, obs_q[i].last, obs_q[i].size,
                 exp_q[i].addr, exp_q[i].beats, exp_q[i].last, exp_q[i].size);
      end
    end
    checks++;
    if (req_ready !== 1'b1 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got rdy=%b vld=%b, required rdy=1 vld=0", name, req_ready, burst_valid);
    end
  endtask

  task automatic test_reject();
    logic [31:0] addrs[3] = '{32'h0000_1002, 32'h0000_1000, 32'h0000_1000};
    int          lens[3]  = '{8, 0, 6};
    for (int i = 0; i < 3; i++) begin
      send_req(addrs[i], lens[i], 2);
      checks++;
      if (req_err !== 1'b1 || burst_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reject%0d_pulse: got err=%b vld=%b rdy=%b, required 1 0 1",
                 i, req_err, burst_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_err !== 1'b0 || burst_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reject%0d_after: got err=%b vld=%b rdy=%b, required 0 0 1",
                 i, req_err, burst_valid, req_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit timeout;
    build_model(32'h0000_0FF0, 16'h40, 2);
    send_req(32'h0000_0FF0, 16'h40, 2);
    burst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (burst_valid !== 1'b1 || burst_addr !== exp_q[0].addr ||
          int'(burst_beats) != exp_q[0].beats || burst_last !== exp_q[0].last) begin
        errors++;
        $display("FAIL stall%0d: got vld=%b addr=%h beats=%0d last=%b, required 1 %h %0d %0d",
                 i, burst_valid, burst_addr, burst_beats, burst_last,
                 exp_q[0].addr, exp_q[0].beats, exp_q[0].last);
      end
      @(negedge clk);
    end
    collect(100, timeout);
    checks++;
    if (timeout || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d bursts timeout=%0d, required %0d", obs_q.size(), timeout, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].beats != exp_q[i].beats ||
          obs_q[i].last != exp_q[i].last) begin
        errors++;
        $display("FAIL stall_burst%0d: got addr=%h beats=%0d last=%0d, required addr=%h beats=%0d last=%0d",
                 i, obs_q[i].addr, obs_q[i].beats, obs_q[i].last,
                 exp_q[i].addr, exp_q[i].beats, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_req(32'h0, 16'h100, 2);
    burst_ready = 1'b1;
    @(negedge clk);
    burst_ready = 1'b0;
    checks++;
    if (burst_valid !== 1'b1 || burst_addr !== 32'h40) begin
      errors++;
      $display("FAIL midreset_second: got vld=%b addr=%h, required 1 00000040", burst_valid, burst_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || burst_valid !== 1'b0 || burst_last !== 1'b0 || req_err !== 1'b0 ||
        burst_addr !== 32'h0 || burst_beats !== 5'd0 || burst_size !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state: rdy=%b vld=%b last=%b err=%b addr=%h beats=%0d size=%0d, required 1 0 0 0 0 0 0",
               req_ready, burst_valid, burst_last, req_err, burst_addr, burst_beats, burst_size);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_err !== 1'b0 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got err=%b vld=%b, required 0 0", req_err, burst_valid);
    end
    test_split("after_reset", 32'h0000_0FF0, 16'h40, 2, 100);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          sz;
    int          len;
    int          mode;
    for (int n = 0; n < 25; n++) begin
      sz   = $urandom_range(3);
      mode = $urandom_range(2);
      a    = $urandom;
      if (mode == 1) a[11:0] = 12'hF00 | 12'($urandom_range(255));
      if (mode == 2) a[31:12] = 20'hFFFFF;
      a   = a & ~((32'd1 << sz) - 32'd1);
      len = $urandom_range(1, 256) << sz;
      test_split($sformatf("rand%0d", n), a, len, sz, 60);
    end
  endtask

  initial begin
    test_reset();
    test_split("cross4k", 32'h0000_0FF0, 16'h40, 2, 100);
    test_split("full16", 32'h0000_0000, 16'h100, 2, 100);
    test_reject();
    test_backpressure();
    test_split("wrap", 32'hFFFF_FFF8, 16, 3, 100);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
